seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/seg7_scan_driver.sv | 117 +++++++++++
 tb/tb_seg7_scan_driver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, types and hex segment table for the 7-segment scan driver.
// Build option SEG7_LZ_BLANK_EN enables leading-zero blanking in the top.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_BLANK;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment decoder.
// Uses the shared table from seg7_pkg.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex7(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment driver with frame-synced shadow load.
// Build option SEG7_LZ_BLANK_EN blanks leading zero digits 3..1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int DIV_W     = 17,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             fd_q;

  logic       tc;
  logic       fb;
  logic [3:0] nib;
  logic [6:0] dec_seg;
  logic [3:0] show;

  assign tc = (cnt_q == DIV_W'(CLK_DIV - 1));
  assign fb = tc && (idx_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tc) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Pending value only reaches the display on a frame boundary.
  always_comb begin
    disp_d = disp_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    if (fb) begin
      if (load) begin
        disp_d = value;
      end else if (pvld_q) begin
        disp_d = pend_q;
      end
      pvld_d = 1'b0;
    end else if (load) begin
      pend_d = value;
      pvld_d = 1'b1;
    end
  end

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble_i (nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    show = 4'hF;
`ifdef SEG7_LZ_BLANK_EN
    show[3] = |disp_q[15:12];
    show[2] = |disp_q[15:8];
    show[1] = |disp_q[15:4];
`endif
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (cnt_q >= DIV_W'(BLANK_CYC)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = show[idx_q] ? dec_seg : SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      pend_q <= '0;
      pvld_q <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      fd_q   <= fb;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with CLK_DIV=4, BLANK_CYC=1.
// Expected frames are queued by the stimulus and checked on each frame_done.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int nchk  = 0;
  int npass = 0;
  int now   = 0;

  // Packed {digit3, digit2, digit1, digit0}
  localparam logic [27:0] E12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [27:0] E2222 = {7'h24, 7'h24, 7'h24, 7'h24};
  localparam logic [27:0] E5555 = {7'h12, 7'h12, 7'h12, 7'h12};
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [27:0] E0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] E0030 = {7'h7F, 7'h7F, 7'h30, 7'h40};
`else
  localparam logic [27:0] E0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] E0030 = {7'h40, 7'h40, 7'h30, 7'h40};
`endif

  logic [27:0] expq[$];

  seg7_scan_driver #(
    .CLK_DIV   (4),
    .DIV_W     (17),
    .BLANK_CYC (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int p);
    if (p - 1 > now) cyc(p - 1 - now);
    now = p - 1;
  endtask

  task automatic load_at(input int p, input logic [15:0] v);
    at(p);
    load  = 1'b1;
    value = v;
    cyc(1);
    now  = p;
    load = 1'b0;
  endtask

  // Monitor: collect one frame of digits, compare on frame_done.
  logic [6:0]  got [4];
  logic [15:0] seq;
  logic [3:0]  prev_an;
  int nblank, nsamp, bad;
  bit first;

  always @(negedge clk) begin
    if (reset) begin
      nblank  = 0;
      nsamp   = 0;
      bad     = 0;
      seq     = '0;
      prev_an = 4'hF;
      first   = 1'b1;
      for (int i = 0; i < 4; i++) got[i] = 7'h7F;
    end else begin
      nsamp++;
      if (dp !== 1'b1) bad++;
      if (an == 4'hF) begin
        nblank++;
        if (seg !== 7'h7F) bad++;
      end else begin
        case (an)
          4'hE: got[0] = seg;
          4'hD: got[1] = seg;
          4'hB: got[2] = seg;
          4'h7: got[3] = seg;
          default: bad++;
        endcase
        if (an != prev_an) seq = {seq[11:0], an};
      end
      prev_an = an;
      if (frame_done) begin
        if (expq.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          check("frame_digits",
                {4'h0, got[3], got[2], got[1], got[0]},
                {4'h0, expq.pop_front()});
        end
        check("anode_order", {16'h0, seq}, 32'h0000EDB7);
        check("frame_len", nsamp, first ? 32'd17 : 32'd16);
        check("blank_cycles", nblank, first ? 32'd5 : 32'd4);
        check("blank_seg_dp", bad, 32'd0);
        nblank  = 0;
        nsamp   = 0;
        bad     = 0;
        seq     = '0;
        prev_an = 4'hF;
        first   = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    cyc(3);
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_dp", {31'h0, dp}, 32'h1);
    check("rst_fd", {31'h0, frame_done}, 32'h0);

    expq.push_back(E0000);
    expq.push_back(E12AF);
    expq.push_back(E2222);
    expq.push_back(E5555);
    expq.push_back(E5555);
    reset = 1'b0;
    now   = 0;
    cyc(1);
    now = 1;
    check("post_rel_an1", {28'h0, an}, 32'hF);
    cyc(1);
    now = 2;
    check("post_rel_an2", {28'h0, an}, 32'hE);
    check("post_rel_seg2", {25'h0, seg}, 32'h40);

    load_at(8, 16'h12AF);
    load_at(20, 16'h1111);
    load_at(24, 16'h2222);
    load_at(40, 16'h9999);
    load_at(48, 16'h5555);
    load_at(84, 16'h7777);
    at(91);
    check("pre_rst_an_digit2", {28'h0, an}, 32'hB);
    check("q_empty_ep1", expq.size(), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_an", {28'h0, an}, 32'hF);
    check("midrst_seg", {25'h0, seg}, 32'h7F);
    check("midrst_fd", {31'h0, frame_done}, 32'h0);
    cyc(3);

    expq.push_back(E0000);
    expq.push_back(E0000);
    expq.push_back(E0030);
    reset = 1'b0;
    now   = 0;
    load_at(24, 16'h0030);
    at(50);
    check("q_empty_ep2", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
